// File: rtl/wishbone_pkg.sv
// Shared Wishbone slave definitions: responder FSM states, word-index geometry
// and the byte-lane merge used by byte-enabled registers.
package wishbone_pkg;

   typedef enum logic [1:0] {
      WBS_IDLE = 2'd0,
      WBS_WAIT = 2'd1,
      WBS_RESP = 2'd2
   } wb_slv_state_t;

   localparam int WB_SLV_IDX_LSB = 2;
   localparam int WB_SLV_IDX_MSB = 27;
   localparam int WB_SLV_LANES   = 4;

   function automatic logic [31:0] wb_lane_merge(input logic [31:0] old_word,
                                                 input logic [31:0] new_word,
                                                 input logic [3:0]  sel);
      logic [31:0] res;
      res = old_word;
      for (int b = 0; b < WB_SLV_LANES; b++) begin
         if (sel[b]) begin
            res[8*b +: 8] = new_word[8*b +: 8];
         end else begin
            res[8*b +: 8] = old_word[8*b +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/wb_slave_mem_if.sv
// Wishbone B.3 slave-slot bundle: shared slave inputs plus this slot's strobe
// and its termination/read-data return path.
interface wb_slave_mem_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                  s_cyc;
   logic                  s_stb;
   logic                  s_we;
   logic [ADDR_WIDTH-1:0] s_addr;
   logic [DATA_WIDTH-1:0] s_wdata;
   logic [7:0]            s_sel;
   logic [2:0]            s_cti;
   logic [1:0]            s_bte;
   logic [DATA_WIDTH-1:0] s_rdata;
   logic                  s_ack;
   logic                  s_err;
   logic                  s_rty;

   modport master (
      output s_cyc, s_stb, s_we, s_addr, s_wdata, s_sel, s_cti, s_bte,
      input  s_rdata, s_ack, s_err, s_rty
   );

   modport slave (
      input  s_cyc, s_stb, s_we, s_addr, s_wdata, s_sel, s_cti, s_bte,
      output s_rdata, s_ack, s_err, s_rty
   );
endinterface

// File: rtl/wb_slave_ram.sv
// Single-port byte-enabled word RAM with synchronous read; the read register
// returns zero whenever no read is issued so it can feed the bus directly.
module wb_slave_ram #(
   parameter int DEPTH = 1024,
   parameter int AW    = 10,
   parameter int DW    = 32
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 we,
   input  logic                                 re,
   input  logic [AW-1:0]                        addr,
   input  logic [DW-1:0]                        wdata,
   input  logic [wishbone_pkg::WB_SLV_LANES-1:0] sel,
   output logic [DW-1:0]                        rdata
);
   import wishbone_pkg::*;

   logic [DW-1:0] mem_r [DEPTH];
   logic [DW-1:0] rdata_r;

   // Byte-lane writes; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (we && !rst) begin
         for (int b = 0; b < WB_SLV_LANES; b++) begin
            if (sel[b]) begin
               mem_r[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

   // Read register: holds data only for the cycle following an issued read.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_r <= '0;
      end else if (re) begin
         rdata_r <= mem_r[addr];
      end else begin
         rdata_r <= '0;
      end
   end

   assign rdata = rdata_r;

endmodule

// File: rtl/wb_slave_mem.sv
// Wishbone B.3 classic slave over a byte-enabled RAM with registered, optionally
// wait-stated responses. Optional doorbell word enabled by WB_SLAVE_MEM_DOORBELL_EN.
module wb_slave_mem #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int MEM_DEPTH   = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic           clk,
   input  logic           rst,
   wb_slave_mem_if.slave  bus,
   output logic           irq
);
   import wishbone_pkg::*;

   localparam int              RAM_AW    = $clog2(MEM_DEPTH);
   localparam int              IDX_W     = WB_SLV_IDX_MSB - WB_SLV_IDX_LSB + 1;
   localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(MEM_DEPTH);
   localparam logic [2:0]      WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

   wb_slv_state_t state_r, state_nx;
   logic [2:0]    cnt_r, cnt_nx;
   logic          ack_r, err_r;
   logic          issue_s;
   logic          req_s;

   logic [IDX_W-1:0] bus_idx_s;
   logic             bus_aligned_s;
   logic             bus_ram_hit_s;

   logic                    cap_ram_hit_r;
   logic [RAM_AW-1:0]       cap_idx_r;
   logic                    cap_we_r;
   logic [WB_SLV_LANES-1:0] cap_sel_r;
   logic [DATA_WIDTH-1:0]   cap_wdata_r;

   logic                    cur_ram_hit_s;
   logic                    cur_db_hit_s;
   logic                    cur_legal_s;
   logic [RAM_AW-1:0]       cur_idx_s;
   logic                    cur_we_s;
   logic [WB_SLV_LANES-1:0] cur_sel_s;
   logic [DATA_WIDTH-1:0]   cur_wdata_s;

   logic                  ram_we_s;
   logic                  ram_re_s;
   logic [DATA_WIDTH-1:0] ram_q_s;
   logic [DATA_WIDTH-1:0] db_q_s;
   logic                  unused_s;

   assign req_s         = bus.s_cyc & bus.s_stb;
   assign bus_idx_s     = bus.s_addr[WB_SLV_IDX_MSB:WB_SLV_IDX_LSB];
   assign bus_aligned_s = (bus.s_addr[WB_SLV_IDX_LSB-1:0] == 2'b00);
   assign bus_ram_hit_s = bus_aligned_s & (bus_idx_s < DEPTH_IDX);
   assign unused_s      = ^{bus.s_addr[ADDR_WIDTH-1:WB_SLV_IDX_MSB+1],
                            bus.s_sel[7:WB_SLV_LANES], bus.s_cti, bus.s_bte};

   // Next-state and response-issue decode.
   always_comb begin
      state_nx = state_r;
      cnt_nx   = cnt_r;
      issue_s  = 1'b0;
      case (state_r)
         WBS_IDLE: begin
            if (req_s) begin
               if (WAIT_STATES == 0) begin
                  state_nx = WBS_RESP;
                  issue_s  = 1'b1;
               end else begin
                  state_nx = WBS_WAIT;
                  cnt_nx   = WAIT_LOAD;
               end
            end else begin
               state_nx = WBS_IDLE;
            end
         end
         WBS_WAIT: begin
            // Master gave up mid-wait: drop the beat silently.
            if (!req_s) begin
               state_nx = WBS_IDLE;
               cnt_nx   = 3'd0;
            end else if (cnt_r == 3'd0) begin
               state_nx = WBS_RESP;
               issue_s  = 1'b1;
            end else begin
               cnt_nx = cnt_r - 3'd1;
            end
         end
         WBS_RESP: begin
            state_nx = WBS_IDLE;
         end
         default: begin
            state_nx = WBS_IDLE;
            cnt_nx   = 3'd0;
         end
      endcase
   end

   // State, wait counter and registered terminations.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= WBS_IDLE;
         cnt_r   <= 3'd0;
         ack_r   <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         state_r <= state_nx;
         cnt_r   <= cnt_nx;
         ack_r   <= issue_s & cur_legal_s;
         err_r   <= issue_s & ~cur_legal_s;
      end
   end

   // Beat capture at acceptance so bus changes during WAIT are ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         cap_ram_hit_r <= 1'b0;
         cap_idx_r     <= '0;
         cap_we_r      <= 1'b0;
         cap_sel_r     <= '0;
         cap_wdata_r   <= '0;
      end else if ((state_r == WBS_IDLE) && req_s) begin
         cap_ram_hit_r <= bus_ram_hit_s;
         cap_idx_r     <= bus_idx_s[RAM_AW-1:0];
         cap_we_r      <= bus.s_we;
         cap_sel_r     <= bus.s_sel[WB_SLV_LANES-1:0];
         cap_wdata_r   <= bus.s_wdata;
      end else begin
         cap_ram_hit_r <= cap_ram_hit_r;
         cap_idx_r     <= cap_idx_r;
         cap_we_r      <= cap_we_r;
         cap_sel_r     <= cap_sel_r;
         cap_wdata_r   <= cap_wdata_r;
      end
   end

   // With no wait states the beat issues straight from the live bus.
   always_comb begin
      if (state_r == WBS_WAIT) begin
         cur_ram_hit_s = cap_ram_hit_r;
         cur_idx_s     = cap_idx_r;
         cur_we_s      = cap_we_r;
         cur_sel_s     = cap_sel_r;
         cur_wdata_s   = cap_wdata_r;
      end else begin
         cur_ram_hit_s = bus_ram_hit_s;
         cur_idx_s     = bus_idx_s[RAM_AW-1:0];
         cur_we_s      = bus.s_we;
         cur_sel_s     = bus.s_sel[WB_SLV_LANES-1:0];
         cur_wdata_s   = bus.s_wdata;
      end
   end

   assign cur_legal_s = cur_ram_hit_s | cur_db_hit_s;
   assign ram_we_s    = issue_s & cur_ram_hit_s & cur_we_s & ~rst;
   assign ram_re_s    = issue_s & cur_ram_hit_s & ~cur_we_s & ~rst;

   wb_slave_ram #(
      .DEPTH (MEM_DEPTH),
      .AW    (RAM_AW),
      .DW    (DATA_WIDTH)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (ram_we_s),
      .re    (ram_re_s),
      .addr  (cur_idx_s),
      .wdata (cur_wdata_s),
      .sel   (cur_sel_s),
      .rdata (ram_q_s)
   );

`ifdef WB_SLAVE_MEM_DOORBELL_EN
   logic                  bus_db_hit_s;
   logic                  cap_db_hit_r;
   logic [DATA_WIDTH-1:0] db_r;
   logic [DATA_WIDTH-1:0] db_q_r;
   logic                  irq_r;

   assign bus_db_hit_s = bus_aligned_s & (bus_idx_s == DEPTH_IDX);
   assign cur_db_hit_s = (state_r == WBS_WAIT) ? cap_db_hit_r : bus_db_hit_s;

   // Doorbell decode captured alongside the rest of the beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         cap_db_hit_r <= 1'b0;
      end else if ((state_r == WBS_IDLE) && req_s) begin
         cap_db_hit_r <= bus_db_hit_s;
      end else begin
         cap_db_hit_r <= cap_db_hit_r;
      end
   end

   // Doorbell: write stores and raises irq, read returns value and clears irq.
   always_ff @(posedge clk) begin
      if (rst) begin
         db_r   <= '0;
         db_q_r <= '0;
         irq_r  <= 1'b0;
      end else if (issue_s && cur_db_hit_s && cur_we_s) begin
         db_r   <= wb_lane_merge(db_r, cur_wdata_s, cur_sel_s);
         db_q_r <= '0;
         irq_r  <= 1'b1;
      end else if (issue_s && cur_db_hit_s) begin
         db_r   <= db_r;
         db_q_r <= db_r;
         irq_r  <= 1'b0;
      end else begin
         db_r   <= db_r;
         db_q_r <= '0;
         irq_r  <= irq_r;
      end
   end

   assign db_q_s = db_q_r;
   assign irq    = irq_r;
`else
   assign cur_db_hit_s = 1'b0;
   assign db_q_s       = '0;
   assign irq          = 1'b0;
`endif

   assign bus.s_ack   = ack_r;
   assign bus.s_err   = err_r;
   assign bus.s_rty   = 1'b0;
   assign bus.s_rdata = ram_q_s | db_q_s;

endmodule
